qam_bit_scheduler: RTL and testbench
====================================

Name: qam_bit_scheduler

Overview:
- Frame-level controller in front of the QAM/QPSK bit-to-symbol mapper.
- Two byte sources share the mapper's serial input: header (hdr) and payload (pay).
- Arbitrates between them, serialises granted bytes MSB-first, and drives DATAIN_EN/DATAIN_BIT.
- DATAIN_EN stays high, unbroken, for a whole frame. It drops for a guard gap between frames so the mapper's bit counter realigns.

Parameters:
- GAP_CYCLES, 4: idle cycles with DATAIN_EN low after each frame; legal range 1..15.
- PREAMBLE, 16'hA5A5: pattern sent before the frame body when PREAMBLE_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low.
- hdr_req  in  1  header frame request; held until its frame_done.
- hdr_len  in  8  header length in bytes; stable while hdr_req is high.
- hdr_byte  in  8  current header byte; first-word-fall-through, always valid once granted.
- hdr_rd  out  1  one-cycle pulse: hdr_byte consumed, present next byte.
- pay_req, pay_len, pay_byte, pay_rd: same as the hdr_* ports, for the payload source.
- grant_hdr  out  1  high while a header frame is in service.
- grant_pay  out  1  high while a payload frame is in service.
- frame_done  out  1  one-cycle pulse at end of each frame.
- DATAIN_EN  out  1  bit-valid to the mapper.
- DATAIN_BIT  out  1  serial bit to the mapper, MSB of each byte first.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, last_grant = pay. Reset mid-frame aborts the frame at once: no further rd pulses, no frame_done.
- States: IDLE, LOAD, SHIFT, GAP (PRE is added by the optional feature).
- IDLE:
  - If only one req is high, select it.
  - If both are high, select the source not granted last (round-robin). After reset the header therefore wins first.
  - Go to LOAD.
- LOAD (1 cycle):
  - grant_x = 1; latch len into an 8-bit byte counter.
  - If len = 0: pulse frame_done, go to GAP; no rd pulse and no DATAIN_EN.
  - Otherwise: load x_byte into an 8-bit shift register, pulse x_rd, go to SHIFT.
- SHIFT:
  - DATAIN_EN = 1, DATAIN_BIT = shift-register MSB; shift left each cycle; 3-bit bit counter.
  - On bit 7 of a byte with bytes remaining: load the next byte and pulse x_rd in the same cycle, so there is no EN bubble.
  - On bit 7 of the last byte: go to GAP.
- GAP:
  - DATAIN_EN = 0, grant cleared, frame_done pulsed in the first GAP cycle.
  - Stay GAP_CYCLES cycles, then go to IDLE.
- Latency: req sampled in IDLE at cycle N → LOAD at N+1 → first DATAIN_EN at N+2.
- Frame length: 8*len EN cycles, contiguous.
- last_grant updates in LOAD.
- A req still high after frame_done starts a new frame; it is arbitrated again in IDLE.
- Requests arriving during LOAD, SHIFT or GAP wait; they are never lost while held.
- rd pulses per frame = len exactly.
- DATAIN_BIT = 0 whenever DATAIN_EN = 0.

Optional Feature:
- Macro: QAM_SCHED_PREAMBLE_EN.
- Defined:
  - Adds state PRE between LOAD and SHIFT; LOAD still latches the first byte and pulses rd.
  - PRE lasts 16 cycles with DATAIN_EN = 1, emitting PREAMBLE MSB-first, then enters SHIFT with no gap.
  - Frame = 16 + 8*len EN cycles.
  - len = 0 sends no preamble.
- Undefined: no PRE state; behaviour exactly as above.

Test Plan:
- Header only, hdr_len=1, hdr_byte=0xB4 → DATAIN_EN high 8 cycles starting 2 cycles after hdr_req; bits 1,0,1,1,0,1,0,0; hdr_rd pulses once (in LOAD); frame_done one pulse on the first EN-low cycle.
- Payload, pay_len=3, bytes 0x01,0x80,0xFF → 24 contiguous EN cycles carrying bits 00000001 10000000 11111111; pay_rd pulses at LOAD, LOAD+8 and LOAD+16.
- Both req high after reset, each len=1, GAP_CYCLES=4 → header frame first, then 4 EN-low cycles, 1 IDLE and 1 LOAD cycle, then payload frame. Both requests re-raised → header again (round-robin).
- hdr_len=0 → grant_hdr high for 1 cycle, frame_done pulse, DATAIN_EN stays 0, hdr_rd never pulses.
- rst driven low at bit 12 of a 3-byte frame → next edge all outputs 0. After release, a new pay_req len=1 is served with normal 2-cycle latency.
- QAM_SCHED_PREAMBLE_EN defined, len=1, byte 0x00 → 24 EN cycles: bits 1010010110100101 followed by eight 0s; rd pulses once, in LOAD.

Source files
------------

// File: rtl/qam_bit_scheduler.sv
// rtl/qam_bit_scheduler.sv - header/payload frame arbiter and MSB-first serialiser for the QAM mapper
// Optional feature macro: QAM_SCHED_PREAMBLE_EN (16-bit preamble ahead of each non-empty frame)
module qam_bit_scheduler #(
  parameter int GAP_CYCLES = 4
`ifdef QAM_SCHED_PREAMBLE_EN
  ,
  parameter logic [15:0] PREAMBLE = 16'hA5A5
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_req,
  input  logic [7:0] hdr_len,
  input  logic [7:0] hdr_byte,
  output logic       hdr_rd,
  input  logic       pay_req,
  input  logic [7:0] pay_len,
  input  logic [7:0] pay_byte,
  output logic       pay_rd,
  output logic       grant_hdr,
  output logic       grant_pay,
  output logic       frame_done,
  output logic       DATAIN_EN,
  output logic       DATAIN_BIT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
`ifdef QAM_SCHED_PREAMBLE_EN
  localparam logic [2:0] S_PRE   = 3'd4;
`endif

  // Gap counter runs GAP_CYCLES-1 down to 0, one GAP cycle per value.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [2:0] r_state;
  logic       r_sel_hdr;   // source of the frame in service
  logic       r_last_hdr;  // round-robin memory: last grant went to header
  logic [7:0] r_cnt;       // in LOAD: frame length; afterwards: bytes still to fetch
  logic [7:0] r_sr;        // remaining bits of the current byte, next bit at [7]
  logic [2:0] r_bit;       // index of the bit currently on DATAIN_BIT
  logic [3:0] r_gap;
`ifdef QAM_SCHED_PREAMBLE_EN
  logic [3:0] r_pre;       // index of the preamble bit currently on DATAIN_BIT
`endif

  logic       w_pick_hdr;
  logic [7:0] w_pick_len;
  logic [7:0] w_byte;

  // Header wins when alone or when payload was served last.
  assign w_pick_hdr = hdr_req && (!pay_req || !r_last_hdr);
  assign w_pick_len = w_pick_hdr ? hdr_len : pay_len;
  assign w_byte     = r_sel_hdr ? hdr_byte : pay_byte;

  // Frame sequencing; every output is a flop that describes the cycle after the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sel_hdr  <= 1'b0;
      r_last_hdr <= 1'b0;
      r_cnt      <= 8'd0;
      r_sr       <= 8'd0;
      r_bit      <= 3'd0;
      r_gap      <= 4'd0;
`ifdef QAM_SCHED_PREAMBLE_EN
      r_pre      <= 4'd0;
`endif
      hdr_rd     <= 1'b0;
      pay_rd     <= 1'b0;
      grant_hdr  <= 1'b0;
      grant_pay  <= 1'b0;
      frame_done <= 1'b0;
      DATAIN_EN  <= 1'b0;
      DATAIN_BIT <= 1'b0;
    end else begin
      hdr_rd     <= 1'b0;
      pay_rd     <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hdr_req || pay_req) begin
            r_state    <= S_LOAD;
            r_sel_hdr  <= w_pick_hdr;
            r_last_hdr <= w_pick_hdr;
            grant_hdr  <= w_pick_hdr;
            grant_pay  <= !w_pick_hdr;
            r_cnt      <= w_pick_len;
            // The rd pulse is visible during LOAD; the first byte is captured as it ends.
            if (w_pick_len != 8'd0) begin
              hdr_rd <= w_pick_hdr;
              pay_rd <= !w_pick_hdr;
            end
          end
        end
        S_LOAD: begin
          if (r_cnt == 8'd0) begin
            r_state    <= S_GAP;
            grant_hdr  <= 1'b0;
            grant_pay  <= 1'b0;
            frame_done <= 1'b1;
            r_gap      <= GAP_LAST;
          end else begin
            r_cnt     <= r_cnt - 8'd1;
            DATAIN_EN <= 1'b1;
`ifdef QAM_SCHED_PREAMBLE_EN
            r_state    <= S_PRE;
            r_sr       <= w_byte;
            r_pre      <= 4'd0;
            DATAIN_BIT <= PREAMBLE[15];
`else
            r_state    <= S_SHIFT;
            r_sr       <= {w_byte[6:0], 1'b0};
            r_bit      <= 3'd0;
            DATAIN_BIT <= w_byte[7];
`endif
          end
        end
`ifdef QAM_SCHED_PREAMBLE_EN
        S_PRE: begin
          if (r_pre == 4'd15) begin
            r_state    <= S_SHIFT;
            r_sr       <= {r_sr[6:0], 1'b0};
            r_bit      <= 3'd0;
            DATAIN_BIT <= r_sr[7];
          end else begin
            r_pre      <= r_pre + 4'd1;
            DATAIN_BIT <= PREAMBLE[4'd14 - r_pre];
          end
        end
`endif
        S_SHIFT: begin
          if (r_bit == 3'd7) begin
            if (r_cnt != 8'd0) begin
              // Next byte follows directly, keeping DATAIN_EN unbroken.
              r_cnt      <= r_cnt - 8'd1;
              r_sr       <= {w_byte[6:0], 1'b0};
              r_bit      <= 3'd0;
              DATAIN_BIT <= w_byte[7];
            end else begin
              r_state    <= S_GAP;
              DATAIN_EN  <= 1'b0;
              DATAIN_BIT <= 1'b0;
              grant_hdr  <= 1'b0;
              grant_pay  <= 1'b0;
              frame_done <= 1'b1;
              r_gap      <= GAP_LAST;
            end
          end else begin
            r_sr       <= {r_sr[6:0], 1'b0};
            r_bit      <= r_bit + 3'd1;
            DATAIN_BIT <= r_sr[7];
            // Pulse rd during the last bit so the next byte is sampled as that bit ends.
            if (r_bit == 3'd6 && r_cnt != 8'd0) begin
              hdr_rd <= r_sel_hdr;
              pay_rd <= !r_sel_hdr;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_bit_scheduler.sv
// tb/tb_qam_bit_scheduler.sv - self-checking bench for qam_bit_scheduler against a frame timeline model
module tb_qam_bit_scheduler;

  localparam int GAP = 4;
`ifdef QAM_SCHED_PREAMBLE_EN
  localparam int PRE_LEN = 16;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam logic [15:0] PRE_PAT = 16'hA5A5;

  logic       clk = 1'b0;
  logic       rst;
  logic       hdr_req, pay_req;
  logic [7:0] hdr_len, pay_len, hdr_byte, pay_byte;
  logic       hdr_rd, pay_rd, grant_hdr, grant_pay, frame_done, DATAIN_EN, DATAIN_BIT;

  always #5 clk = ~clk;

  qam_bit_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .hdr_req(hdr_req), .hdr_len(hdr_len), .hdr_byte(hdr_byte), .hdr_rd(hdr_rd),
    .pay_req(pay_req), .pay_len(pay_len), .pay_byte(pay_byte), .pay_rd(pay_rd),
    .grant_hdr(grant_hdr), .grant_pay(grant_pay), .frame_done(frame_done),
    .DATAIN_EN(DATAIN_EN), .DATAIN_BIT(DATAIN_BIT)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_reset = 1'b1;

  // Expected outputs per cycle {en, bit, grant_hdr, grant_pay, hdr_rd, pay_rd, frame_done}; absent = all 0.
  logic [6:0] exp_map [int];
  int  m_free = 0;
  bit  m_last_hdr = 1'b0;
  int  mh_ptr = 0, mp_ptr = 0;
  int  done_h = -1, done_p = -1;

  logic [7:0] h_mem[$], p_mem[$];
  int  h_lens[$], p_lens[$];
  int  h_ptr = 0, p_ptr = 0;

  int  n_en, n_hrd, n_prd, n_done, n_gh, first_en, first_en_h, first_en_p, tot_frames, tot_bytes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] rec(input bit en, input bit b, input bit gh, input bit gp,
                                     input bit hr, input bit pr, input bit dn);
    return {en, b, gh, gp, hr, pr, dn};
  endfunction

  task automatic drive_inputs();
    hdr_req  = h_lens.size() > 0;
    hdr_len  = (h_lens.size() > 0) ? 8'(h_lens[0]) : 8'd0;
    hdr_byte = (h_ptr < h_mem.size()) ? h_mem[h_ptr] : 8'd0;
    pay_req  = p_lens.size() > 0;
    pay_len  = (p_lens.size() > 0) ? 8'(p_lens[0]) : 8'd0;
    pay_byte = (p_ptr < p_mem.size()) ? p_mem[p_ptr] : 8'd0;
  endtask

  task automatic clr_counts();
    n_en = 0; n_hrd = 0; n_prd = 0; n_done = 0; n_gh = 0;
    first_en = -1; first_en_h = -1; first_en_p = -1; tot_frames = 0; tot_bytes = 0;
  endtask

  // Lays out the whole frame timeline once arbitration is decided in idle cycle c.
  task automatic model_schedule(input int c);
    bit hsel;
    int len, base, end_c, j;
    logic [7:0] bb;
    logic [15:0] pat;
    bit bitv;
    pat  = PRE_PAT;
    hsel = (h_lens.size() > 0) && (p_lens.size() == 0 || !m_last_hdr);
    len  = hsel ? h_lens[0] : p_lens[0];
    base = hsel ? mh_ptr : mp_ptr;
    exp_map[c + 1] = rec(0, 0, hsel, !hsel, hsel && len > 0, !hsel && len > 0, 0);
    if (len == 0) begin
      end_c = c + 2;
    end else begin
      for (int i = 0; i < PRE_LEN + 8 * len; i++) begin
        if (i < PRE_LEN) begin
          bitv = pat[15 - i];
        end else begin
          j = i - PRE_LEN;
          bb = hsel ? h_mem[base + j / 8] : p_mem[base + j / 8];
          bitv = bb[7 - (j % 8)];
        end
        exp_map[c + 2 + i] = rec(1, bitv, hsel, !hsel, 0, 0, 0);
      end
      for (int k = 1; k < len; k++)
        exp_map[c + 1 + PRE_LEN + 8 * k] |= (hsel ? 7'b0000100 : 7'b0000010);
      end_c = c + 2 + PRE_LEN + 8 * len;
    end
    exp_map[end_c] = rec(0, 0, 0, 0, 0, 0, 1);
    m_free = end_c + GAP;
    m_last_hdr = hsel;
    if (hsel) begin mh_ptr += len; done_h = end_c; end
    else      begin mp_ptr += len; done_p = end_c; end
  endtask

  task automatic tick();
    logic [6:0] obs, ev;
    bit rh, rp, ph, pp;
    @(negedge clk);
    obs = {DATAIN_EN, DATAIN_BIT, grant_hdr, grant_pay, hdr_rd, pay_rd, frame_done};
    ev  = exp_map.exists(cyc) ? exp_map[cyc] : 7'd0;
    check("outputs", {25'd0, obs}, {25'd0, ev});
    n_en += int'(DATAIN_EN); n_hrd += int'(hdr_rd); n_prd += int'(pay_rd);
    n_done += int'(frame_done); n_gh += int'(grant_hdr);
    if (DATAIN_EN === 1'b1 && first_en < 0) first_en = cyc;
    if (DATAIN_EN === 1'b1 && grant_hdr === 1'b1 && first_en_h < 0) first_en_h = cyc;
    if (DATAIN_EN === 1'b1 && grant_pay === 1'b1 && first_en_p < 0) first_en_p = cyc;
    if (!in_reset && cyc >= m_free && (h_lens.size() > 0 || p_lens.size() > 0))
      model_schedule(cyc);
    rh = (hdr_rd === 1'b1); rp = (pay_rd === 1'b1);
    ph = (cyc == done_h);   pp = (cyc == done_p);
    @(posedge clk);
    #1;
    if (rh) h_ptr++;
    if (rp) p_ptr++;
    if (ph) begin void'(h_lens.pop_front()); done_h = -1; end
    if (pp) begin void'(p_lens.pop_front()); done_p = -1; end
    cyc++;
    drive_inputs();
  endtask

  task automatic push_req(input bit hdr, input int len, input logic [31:0] d, input bit rnd);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = rnd ? 8'($urandom) : d[31 - 8 * k -: 8];
      if (hdr) h_mem.push_back(b); else p_mem.push_back(b);
    end
    if (hdr) h_lens.push_back(len); else p_lens.push_back(len);
    tot_frames++;
    tot_bytes += len;
    drive_inputs();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((h_lens.size() > 0 || p_lens.size() > 0 || cyc < m_free) && n < max) begin
      tick();
      n++;
    end
    check("drain_timeout", n < max, 1);
  endtask

  task automatic do_reset(input int k);
    int dq[$];
    rst = 1'b0;
    in_reset = 1'b1;
    foreach (exp_map[key]) if (key > cyc) dq.push_back(key);
    foreach (dq[i]) exp_map.delete(dq[i]);
    h_lens.delete(); p_lens.delete(); h_mem.delete(); p_mem.delete();
    h_ptr = 0; p_ptr = 0; mh_ptr = 0; mp_ptr = 0;
    done_h = -1; done_p = -1; m_last_hdr = 1'b0;
    drive_inputs();
    repeat (k) tick();
    rst = 1'b1;
    in_reset = 1'b0;
    m_free = cyc;
  endtask

  initial begin
    int start;
    rst = 1'b0;
    drive_inputs();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    // Reset state: every output low.
    repeat (3) tick();
    rst = 1'b1;
    in_reset = 1'b0;
    m_free = cyc;
    repeat (2) tick();

    // Header only, one byte 0xB4.
    clr_counts();
    start = cyc;
    push_req(1, 1, 32'hB4000000, 0);
    drain(200);
    check("hdr1_en_cycles", n_en, 8 + PRE_LEN);
    check("hdr1_rd_pulses", n_hrd, 1);
    check("hdr1_done_pulses", n_done, 1);
    check("hdr1_latency", first_en - start, 2);

    // Payload, three bytes 0x01 0x80 0xFF.
    clr_counts();
    push_req(0, 3, 32'h0180FF00, 0);
    drain(200);
    check("pay3_en_cycles", n_en, 24 + PRE_LEN);
    check("pay3_rd_pulses", n_prd, 3);

    // Both requesting at once, twice: header wins each round.
    clr_counts();
    push_req(1, 1, 32'h5A000000, 0);
    push_req(0, 1, 32'hC3000000, 0);
    drain(300);
    check("rr_hdr_first", first_en_h < first_en_p, 1);
    check("rr_spacing", first_en_p - first_en_h, 8 + PRE_LEN + GAP + 2);
    clr_counts();
    push_req(1, 1, 32'h0F000000, 0);
    push_req(0, 1, 32'hF0000000, 0);
    drain(300);
    check("rr_hdr_again", first_en_h < first_en_p, 1);
    check("rr_done_pulses", n_done, 2);

    // Zero-length header frame.
    clr_counts();
    push_req(1, 0, 32'h0, 0);
    drain(100);
    check("len0_en_cycles", n_en, 0);
    check("len0_rd_pulses", n_hrd, 0);
    check("len0_done_pulses", n_done, 1);
    check("len0_grant_cycles", n_gh, 1);

    // Reset at bit 12 of a three-byte payload frame, then a fresh one-byte frame.
    clr_counts();
    push_req(0, 3, 32'h3CA55A00, 0);
    repeat (2 + PRE_LEN + 11) tick();
    do_reset(2);
    check("abort_rd_pulses", n_prd, 2);
    check("abort_no_done", n_done, 0);
    clr_counts();
    start = cyc;
    push_req(0, 1, 32'h96000000, 0);
    drain(200);
    check("post_reset_latency", first_en - start, 2);
    check("post_reset_rd", n_prd, 1);

    // Randomised traffic against the timeline model.
    clr_counts();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1 && h_lens.size() < 3) push_req(1, $urandom_range(0, 5), 32'h0, 1);
      if ($urandom_range(0, 1) == 1 && p_lens.size() < 3) push_req(0, $urandom_range(0, 5), 32'h0, 1);
      repeat ($urandom_range(0, 20)) tick();
    end
    drain(10000);
    check("rand_done_pulses", n_done, tot_frames);
    check("rand_rd_pulses", n_hrd + n_prd, tot_bytes);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
